// File: rtl/rs_encode_line_arb.sv
// rs_encode_line_arb
//   Round-robin block arbiter in front of a shared RS line encoder wrapper.
//   A grant covers exactly one RS block of NUM_LINES lines, so blocks never
//   interleave at the encoder. Granted source IDs go into an in-order tag FIFO
//   and are returned with every encoder output line, together with a last flag.
//
//   Build option: RS_ARB_FIXED_PRIO_EN -- when defined, the lowest requesting
//   index always wins and no round-robin pointer exists.
//
// Ports
//   clk, rst                      clock; asynchronous active-high reset
//   src_arb_line_val/_line        per-source line request (source i at [i*DATA_W +: DATA_W])
//   arb_src_line_rdy              per-source ready (only the granted source)
//   arb_encoder_line_val/_line    line to encoder, encoder_arb_line_rdy back
//   encoder_arb_line_val/_line/_parity   encoder output, arb_encoder_line_rdy back
//   arb_dst_line_val/_line/_parity/_src_id/_last   tagged output, dst_arb_line_rdy back
module rs_encode_line_arb #(
  parameter int NUM_SRC      = 4,
  parameter int SRC_W        = $clog2(NUM_SRC),
  // DATA_W / NUM_LINES / PARITY_W must be set to match the encoder wrapper.
  parameter int DATA_W       = 32,
  parameter int NUM_LINES    = 4,
  parameter int PARITY_W     = 16,
  parameter int TAG_LOG2_ELS = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_SRC-1:0]          src_arb_line_val,
  input  logic [NUM_SRC*DATA_W-1:0]   src_arb_line,
  output logic [NUM_SRC-1:0]          arb_src_line_rdy,
  output logic                        arb_encoder_line_val,
  output logic [DATA_W-1:0]           arb_encoder_line,
  input  logic                        encoder_arb_line_rdy,
  input  logic                        encoder_arb_line_val,
  input  logic [DATA_W-1:0]           encoder_arb_line,
  input  logic [PARITY_W-1:0]         encoder_arb_parity,
  output logic                        arb_encoder_line_rdy,
  output logic                        arb_dst_line_val,
  output logic [DATA_W-1:0]           arb_dst_line,
  output logic [PARITY_W-1:0]         arb_dst_parity,
  output logic [SRC_W-1:0]            arb_dst_src_id,
  output logic                        arb_dst_last,
  input  logic                        dst_arb_line_rdy
);

  localparam int CNT_W   = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int TAG_ELS = 1 << TAG_LOG2_ELS;
  localparam logic [CNT_W-1:0]        LAST_CNT = CNT_W'(NUM_LINES - 1);
  localparam logic [TAG_LOG2_ELS:0]   TAG_FULL = (TAG_LOG2_ELS + 1)'(TAG_ELS);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                  state_q, state_d;
  logic [SRC_W-1:0]        grant_id_q, grant_id_d;
  logic [CNT_W-1:0]        in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]        out_cnt_q, out_cnt_d;
  logic [SRC_W-1:0]        tag_mem_q [TAG_ELS];
  logic [SRC_W-1:0]        tag_mem_d [TAG_ELS];
  logic [TAG_LOG2_ELS-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [TAG_LOG2_ELS:0]   tag_cnt_q, tag_cnt_d;

  logic             sel_found;
  logic [SRC_W-1:0] sel_id;
  logic             tag_push, tag_pop, tag_empty, tag_full;
  logic             out_hs, out_last;

  // ---------------------------------------------------------------- selection
`ifdef RS_ARB_FIXED_PRIO_EN
  // Scan high to low so the lowest requesting index is the one left standing.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (src_arb_line_val[i]) begin
        sel_found = 1'b1;
        sel_id    = SRC_W'(i);
      end
    end
  end
`else
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [SRC_W:0]   rr_sum;
  logic [SRC_W-1:0] rr_idx;

  // Scan offsets high to low from rr_ptr; the last hit is the first requester
  // at or after rr_ptr in wrapped order.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    rr_sum    = '0;
    rr_idx    = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      rr_sum = {1'b0, rr_ptr_q} + (SRC_W + 1)'(k);
      if (rr_sum >= (SRC_W + 1)'(NUM_SRC)) rr_sum = rr_sum - (SRC_W + 1)'(NUM_SRC);
      rr_idx = rr_sum[SRC_W-1:0];
      if (src_arb_line_val[rr_idx]) begin
        sel_found = 1'b1;
        sel_id    = rr_idx;
      end
    end
  end
`endif

  // ---------------------------------------------------------------- tag FIFO
  assign tag_empty = (tag_cnt_q == '0);
  assign tag_full  = (tag_cnt_q == TAG_FULL);

  // ---------------------------------------------------------------- input FSM
  always_comb begin
    state_d              = state_q;
    grant_id_d           = grant_id_q;
    in_cnt_d             = in_cnt_q;
`ifndef RS_ARB_FIXED_PRIO_EN
    rr_ptr_d             = rr_ptr_q;
`endif
    tag_push             = 1'b0;
    arb_src_line_rdy     = '0;
    arb_encoder_line_val = 1'b0;
    arb_encoder_line     = '0;
    case (state_q)
      IDLE: begin
        // Full is judged on registered occupancy: a pop this cycle does not
        // open a slot until the next one.
        if (sel_found && !tag_full) begin
          tag_push   = 1'b1;
          grant_id_d = sel_id;
          in_cnt_d   = '0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        arb_encoder_line_val         = src_arb_line_val[grant_id_q];
        arb_encoder_line             = src_arb_line[int'(grant_id_q)*DATA_W +: DATA_W];
        arb_src_line_rdy[grant_id_q] = encoder_arb_line_rdy;
        if (arb_encoder_line_val && encoder_arb_line_rdy) begin
          in_cnt_d = in_cnt_q + 1'b1;
          if (in_cnt_q == LAST_CNT) begin
            state_d = IDLE;
`ifndef RS_ARB_FIXED_PRIO_EN
            rr_ptr_d = (grant_id_q == SRC_W'(NUM_SRC - 1)) ? '0 : grant_id_q + 1'b1;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- output side
  assign arb_dst_line_val     = encoder_arb_line_val & ~tag_empty;
  assign arb_encoder_line_rdy = dst_arb_line_rdy & ~tag_empty;
  assign arb_dst_line         = encoder_arb_line;
  assign arb_dst_parity       = encoder_arb_parity;
  assign arb_dst_src_id       = tag_empty ? '0 : tag_mem_q[tag_rd_q];
  assign out_last             = (out_cnt_q == LAST_CNT);
  assign arb_dst_last         = out_last & ~tag_empty;
  assign out_hs               = encoder_arb_line_val & arb_encoder_line_rdy;
  assign tag_pop              = out_hs & out_last;

  always_comb begin
    tag_mem_d = tag_mem_q;
    tag_wr_d  = tag_wr_q;
    tag_rd_d  = tag_rd_q;
    tag_cnt_d = tag_cnt_q;
    out_cnt_d = out_cnt_q;
    if (tag_push) begin
      tag_mem_d[tag_wr_q] = sel_id;
      tag_wr_d            = tag_wr_q + 1'b1;
    end
    if (tag_pop) tag_rd_d = tag_rd_q + 1'b1;
    case ({tag_push, tag_pop})
      2'b10:   tag_cnt_d = tag_cnt_q + 1'b1;
      2'b01:   tag_cnt_d = tag_cnt_q - 1'b1;
      default: tag_cnt_d = tag_cnt_q;
    endcase
    if (out_hs) out_cnt_d = out_last ? '0 : out_cnt_q + 1'b1;
  end

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
      tag_cnt_q  <= '0;
      for (int i = 0; i < TAG_ELS; i++) tag_mem_q[i] <= '0;
`ifndef RS_ARB_FIXED_PRIO_EN
      rr_ptr_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
      tag_wr_q   <= tag_wr_d;
      tag_rd_q   <= tag_rd_d;
      tag_cnt_q  <= tag_cnt_d;
      tag_mem_q  <= tag_mem_d;
`ifndef RS_ARB_FIXED_PRIO_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end

  // Encoder output with no block in flight means the encoder and this block
  // disagree about what was sent; ready is already held low above.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(encoder_arb_line_val && tag_empty))
        else $error("rs_encode_line_arb: encoder output with empty tag FIFO");
    end
  end

endmodule

// File: tb/tb_rs_encode_line_arb.sv
// Directed bench for rs_encode_line_arb. Per-source line generators, a simple
// in-order encoder model (one cycle latency, parity = ~line) and an expected
// output scoreboard filled when each block is requested.
module tb_rs_encode_line_arb;
  localparam int NUM_SRC = 4, SRC_W = 2, DATA_W = 16, NUM_LINES = 4;
  localparam int PARITY_W = 8, TAG_LOG2_ELS = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NUM_SRC-1:0]        src_val, src_rdy;
  logic [NUM_SRC*DATA_W-1:0] src_line;
  logic                      arb_encoder_line_val, enc_in_rdy, arb_encoder_line_rdy;
  logic [DATA_W-1:0]         arb_encoder_line;
  logic                      enc_val;
  logic [DATA_W-1:0]         enc_line;
  logic [PARITY_W-1:0]       enc_par;
  logic                      dst_val, dst_rdy, dst_last;
  logic [DATA_W-1:0]         dst_line;
  logic [PARITY_W-1:0]       dst_par;
  logic [SRC_W-1:0]          dst_id;

  rs_encode_line_arb #(
    .NUM_SRC(NUM_SRC), .SRC_W(SRC_W), .DATA_W(DATA_W), .NUM_LINES(NUM_LINES),
    .PARITY_W(PARITY_W), .TAG_LOG2_ELS(TAG_LOG2_ELS)
  ) dut (
    .clk(clk), .rst(rst),
    .src_arb_line_val(src_val), .src_arb_line(src_line), .arb_src_line_rdy(src_rdy),
    .arb_encoder_line_val(arb_encoder_line_val), .arb_encoder_line(arb_encoder_line),
    .encoder_arb_line_rdy(enc_in_rdy),
    .encoder_arb_line_val(enc_val), .encoder_arb_line(enc_line),
    .encoder_arb_parity(enc_par), .arb_encoder_line_rdy(arb_encoder_line_rdy),
    .arb_dst_line_val(dst_val), .arb_dst_line(dst_line), .arb_dst_parity(dst_par),
    .arb_dst_src_id(dst_id), .arb_dst_last(dst_last), .dst_arb_line_rdy(dst_rdy)
  );

  // Line content identifies source and per-source sequence number.
  function automatic logic [DATA_W-1:0] mk_line(input int s, input int q);
    logic [3:0]  sv;
    logic [11:0] qv;
    sv = s[3:0];
    qv = q[11:0];
    return {sv, qv};
  endfunction

  // Source model: source g offers lines until sent[g] reaches tot[g].
  int tot[NUM_SRC];
  int sent[NUM_SRC];
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign src_val[g]                   = sent[g] < tot[g];
    assign src_line[g*DATA_W +: DATA_W] = mk_line(g, sent[g]);
  end
  always @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++)
      if (src_val[i] && src_rdy[i]) sent[i] <= sent[i] + 1;
  end

  // Encoder model: in-order line queue, shares rst with the arbiter.
  logic [DATA_W-1:0] enc_q[$];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      enc_q.delete();
      enc_val  <= 1'b0;
      enc_line <= '0;
    end else begin
      if (enc_val && arb_encoder_line_rdy) void'(enc_q.pop_front());
      if (arb_encoder_line_val && enc_in_rdy) enc_q.push_back(arb_encoder_line);
      enc_val  <= (enc_q.size() != 0);
      enc_line <= (enc_q.size() != 0) ? enc_q[0] : '0;
    end
  end
  assign enc_par = ~enc_line[PARITY_W-1:0];

  typedef struct packed {
    logic [SRC_W-1:0]  id;
    logic [DATA_W-1:0] line;
    logic              last;
  } exp_t;
  exp_t sb[$];
  int   exp_seq[NUM_SRC];
  int   n_assert = 0;
  int   n_fail   = 0;
  bit   mirror_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_block(input int s);
    for (int k = 0; k < NUM_LINES; k++)
      sb.push_back('{id: SRC_W'(s), line: mk_line(s, exp_seq[s] + k), last: (k == NUM_LINES - 1)});
    exp_seq[s] += NUM_LINES;
  endtask

  // One cycle: check at the falling edge, return just after the next rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (mirror_en && enc_val)
      chk("enc_rdy_mirror", 32'(arb_encoder_line_rdy), 32'(dst_rdy));
    if (!rst && dst_val && dst_rdy) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("dst_id",     32'(dst_id),   32'(e.id));
        chk("dst_line",   32'(dst_line), 32'(e.line));
        chk("dst_last",   32'(dst_last), 32'(e.last));
        chk("dst_parity", 32'(dst_par),  32'(PARITY_W'(~e.line)));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag, input int budget, input bit toggle);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
      if (toggle) dst_rdy = ~dst_rdy;
    end
    chk({tag, "_drained"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_src_rdy"}, 32'(src_rdy),              32'd0);
    chk({tag, "_enc_val"}, 32'(arb_encoder_line_val), 32'd0);
    chk({tag, "_enc_line"},32'(arb_encoder_line),     32'd0);
    chk({tag, "_dst_val"}, 32'(dst_val),              32'd0);
    chk({tag, "_dst_last"},32'(dst_last),             32'd0);
    chk({tag, "_dst_id"},  32'(dst_id),               32'd0);
    chk({tag, "_enc_rdy"}, 32'(arb_encoder_line_rdy), 32'd0);
  endtask

  initial begin
    int base;
    int n;
    for (int i = 0; i < NUM_SRC; i++) begin
      tot[i]     = 0;
      exp_seq[i] = 0;
    end
    dst_rdy    = 1'b1;
    enc_in_rdy = 1'b1;
    tot[1]     = 100;  // request held during reset must not be granted
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    tot[1] = sent[1];
    rst    = 1'b0;

    // Single source 2: one idle cycle, then data from the next.
    tot[2] += NUM_LINES;
    exp_block(2);
    @(negedge clk);
    chk("single_idle_rdy", 32'(src_rdy), 32'd0);
    chk("single_idle_val", 32'(arb_encoder_line_val), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("single_grant_rdy", 32'(src_rdy), 32'h4);
    chk("single_first_line", 32'(arb_encoder_line), 32'(mk_line(2, 0)));
    @(posedge clk); #1;
    drain("single", 100, 1'b0);

    // Contention from reset: sources 0, 1, 3, two blocks each.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tot[0] += 2*NUM_LINES; tot[1] += 2*NUM_LINES; tot[3] += 2*NUM_LINES;
`ifdef RS_ARB_FIXED_PRIO_EN
    exp_block(0); exp_block(0); exp_block(1); exp_block(1); exp_block(3); exp_block(3);
`else
    exp_block(0); exp_block(1); exp_block(3); exp_block(0); exp_block(1); exp_block(3);
`endif
    drain("contention", 300, 1'b0);

    // Tag FIFO full: four blocks accepted, fifth waits for a drain.
    dst_rdy = 1'b0;
    base    = sent[1];
    tot[1] += 5*NUM_LINES;
    for (int b = 0; b < 5; b++) exp_block(1);
    repeat (40) tick();
    chk("full_lines_in", 32'(sent[1] - base), 32'(4*NUM_LINES));
    chk("full_src_rdy",  32'(src_rdy), 32'd0);
    chk("full_enc_val",  32'(arb_encoder_line_val), 32'd0);
    chk("full_enc_rdy",  32'(arb_encoder_line_rdy), 32'd0);
    dst_rdy = 1'b1;
    drain("tag_full", 300, 1'b0);

    // Downstream backpressure toggling every cycle; rr_ptr now at 2.
    mirror_en = 1'b1;
    tot[0] += 2*NUM_LINES; tot[2] += 2*NUM_LINES;
`ifdef RS_ARB_FIXED_PRIO_EN
    exp_block(0); exp_block(0); exp_block(2); exp_block(2);
`else
    exp_block(2); exp_block(0); exp_block(2); exp_block(0);
`endif
    drain("backpressure", 300, 1'b1);
    mirror_en = 1'b0;
    dst_rdy   = 1'b1;

    // Reset after line 2 of a block from source 3.
    dst_rdy = 1'b0;
    base    = sent[3];
    tot[3] += NUM_LINES;
    n = 0;
    while (sent[3] - base < 2 && n < 50) begin
      tick();
      n++;
    end
    chk("rst_mid_lines", 32'(sent[3] - base), 32'd2);
    rst = 1'b1;
    #1;
    chk_all_zero("rst_mid");
    tot[3]     = sent[3];
    exp_seq[3] = sent[3];
    sb.delete();
    @(posedge clk); #1;
    rst     = 1'b0;
    dst_rdy = 1'b1;
    tot[1] += NUM_LINES;
    exp_block(1);
    drain("post_rst", 100, 1'b0);

`ifdef RS_ARB_FIXED_PRIO_EN
    // Fixed priority: source 1 beats source 3 every time both request.
    tot[1] += 2*NUM_LINES; tot[3] += 2*NUM_LINES;
    exp_block(1); exp_block(1); exp_block(3); exp_block(3);
    drain("fixed_prio", 300, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
